vga_timing_core: RTL and testbench

- Single-clock timing core for the memory-game display path, driven by the 50 MHz board clock.
- Produces the 25 MHz pixel clock for the VGA DAC, a slow square wave for cursor-repeat logic, and 640x480@60 VGA raster timing: counters sx/sy, hsync, vsync and data-enable.
- Replaces the separate clock dividers and VGA timing generator with one synchronous block.

---
 rtl/vga_timing_core.sv | 117 +++++++++++
 tb/tb_vga_timing_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - 25 MHz pixel clock, slow square wave and 640x480@60 raster timing from one 50 MHz clock
// Optional frame-start pulse output enabled by defining VGA_FRAME_PULSE_EN.
module vga_timing_core #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int SLOW_FREQ_HZ = 1,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic       clock_50M,
    input  logic       reset_n,
    output logic       clock_25M,
    output logic       clock_1Hz,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
`ifdef VGA_FRAME_PULSE_EN
    output logic       frame,
`endif
    output logic       de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HALF    = CLK_FREQ_HZ / (2 * SLOW_FREQ_HZ);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);

    logic [9:0]  sx_next;
    logic [9:0]  sy_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        de_next;
    logic [31:0] slow_cnt;

    // Pixel advance rides on the falling edge of clock_25M (when it is currently 1)
    always_comb begin
        sx_next = sx;
        sy_next = sy;
        if (clock_25M) begin
            if (sx == H_LAST) begin
                sx_next = '0;
                if (sy == V_LAST) begin
                    sy_next = '0;
                end else begin
                    sy_next = sy + 10'd1;
                end
            end else begin
                sx_next = sx + 10'd1;
            end
        end
    end

    always_comb begin
        hsync_next = !(({1'b0, sx_next} >= HS_START) && ({1'b0, sx_next} < HS_END));
        vsync_next = !(({1'b0, sy_next} >= VS_START) && ({1'b0, sy_next} < VS_END));
        de_next    = ({1'b0, sx_next} < H_VIS) && ({1'b0, sy_next} < V_VIS);
    end

    always_ff @(posedge clock_50M or negedge reset_n) begin
        if (!reset_n) begin
            clock_25M <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            de        <= 1'b1;
        end else begin
            clock_25M <= ~clock_25M;
            sx        <= sx_next;
            sy        <= sy_next;
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            de        <= de_next;
        end
    end

`ifdef VGA_FRAME_PULSE_EN
    // Marks the first pixel of vertical blanking; decoded from next-state like the syncs
    always_ff @(posedge clock_50M or negedge reset_n) begin
        if (!reset_n) begin
            frame <= 1'b0;
        end else begin
            frame <= (sx_next == 10'd0) && ({1'b0, sy_next} == V_VIS);
        end
    end
`endif

    always_ff @(posedge clock_50M or negedge reset_n) begin
        if (!reset_n) begin
            slow_cnt  <= '0;
            clock_1Hz <= 1'b0;
        end else if (slow_cnt == HALF_LAST) begin
            slow_cnt  <= '0;
            clock_1Hz <= ~clock_1Hz;
        end else begin
            slow_cnt  <= slow_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - randomized-reset scoreboard bench for vga_timing_core (small and default geometry)
module tb_vga_timing_core;

    typedef struct {
        logic       c25;
        logic       c1;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       a_c25, a_c1, a_hs, a_vs, a_de, a_fr;
    logic [9:0] a_x, a_y;
    logic       b_c25, b_c1, b_hs, b_vs, b_de, b_fr;
    logic [9:0] b_x, b_y;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vga_timing_core #(
        .CLK_FREQ_HZ(20), .SLOW_FREQ_HZ(1),
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_a (
        .clock_50M(clk), .reset_n(reset_n),
        .clock_25M(a_c25), .clock_1Hz(a_c1),
        .sx(a_x), .sy(a_y), .hsync(a_hs), .vsync(a_vs),
`ifdef VGA_FRAME_PULSE_EN
        .frame(a_fr),
`endif
        .de(a_de)
    );

    vga_timing_core dut_b (
        .clock_50M(clk), .reset_n(reset_n),
        .clock_25M(b_c25), .clock_1Hz(b_c1),
        .sx(b_x), .sy(b_y), .hsync(b_hs), .vsync(b_vs),
`ifdef VGA_FRAME_PULSE_EN
        .frame(b_fr),
`endif
        .de(b_de)
    );

`ifndef VGA_FRAME_PULSE_EN
    assign a_fr = 1'b0;
    assign b_fr = 1'b0;
`endif

    // Expected outputs after e clock edges since reset release: pixels advance every second edge
    function automatic exp_t model(int e, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp, int half);
        exp_t r;
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int n  = e / 2;
        int px = n % ht;
        int py = (n / ht) % vt;
        r.c25 = (e % 2) == 1;
        r.c1  = ((e / half) % 2) == 1;
        r.x   = 10'(px);
        r.y   = 10'(py);
        r.hs  = !(px >= ha + hfp && px < ha + hfp + hsw);
        r.vs  = !(py >= va + vfp && py < va + vfp + vsw);
        r.de  = (px < ha) && (py < va);
        r.fr  = (px == 0) && (py == va);
        return r;
    endfunction

    function automatic exp_t model_a(int e);
        return model(e, 16, 4, 6, 4, 10, 2, 2, 3, 10);
    endfunction

    function automatic exp_t model_b(int e);
        return model(e, 640, 16, 96, 48, 480, 10, 2, 33, 25000000);
    endfunction

    task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, exp_t act, exp_t exp);
        chk({tag, ".clock_25M"}, 10'(act.c25), 10'(exp.c25));
        chk({tag, ".clock_1Hz"}, 10'(act.c1), 10'(exp.c1));
        chk({tag, ".sx"}, act.x, exp.x);
        chk({tag, ".sy"}, act.y, exp.y);
        chk({tag, ".hsync"}, 10'(act.hs), 10'(exp.hs));
        chk({tag, ".vsync"}, 10'(act.vs), 10'(exp.vs));
        chk({tag, ".de"}, 10'(act.de), 10'(exp.de));
`ifdef VGA_FRAME_PULSE_EN
        chk({tag, ".frame"}, 10'(act.fr), 10'(exp.fr));
`endif
    endtask

    function automatic exp_t cap_a();
        exp_t r;
        r.c25 = a_c25; r.c1 = a_c1; r.x = a_x; r.y = a_y;
        r.hs = a_hs; r.vs = a_vs; r.de = a_de; r.fr = a_fr;
        return r;
    endfunction

    function automatic exp_t cap_b();
        exp_t r;
        r.c25 = b_c25; r.c1 = b_c1; r.x = b_x; r.y = b_y;
        r.hs = b_hs; r.vs = b_vs; r.de = b_de; r.fr = b_fr;
        return r;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (qa.size() > 0) cmp("a", cap_a(), qa.pop_front());
            if (qb.size() > 0) cmp("b", cap_b(), qb.pop_front());
        end
    end

    initial begin
        int e = 0;
        int hold = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            #2;
            if (i < 3) begin
                reset_n = 1'b0;
            end else if (i == 3) begin
                reset_n = 1'b1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) reset_n = 1'b1;
            end else if (i == 2600 || (i > 2300 && $urandom_range(0, 999) == 0)) begin
                reset_n = 1'b0;
                hold = $urandom_range(1, 3);
                #1;
                cmp("a_async", cap_a(), model_a(0));
                cmp("b_async", cap_b(), model_b(0));
            end
            @(posedge clk);
            if (!reset_n) e = 0;
            else e++;
            qa.push_back(model_a(e));
            qb.push_back(model_b(e));
        end
        @(negedge clk);
        #3;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", qa.size() + qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
